register_file_n: RTL and testbench
==================================

// Module: register_file_n
// PURPOSE
//  Parametrised multi-entry register file: successor to the single register_n, generalised to
//  DEPTH entries of N bits, two read ports, one write port. Adds write-to-read bypass, an optional
//  hardwired-zero entry 0, and a sequenced bulk clear (one entry per cycle, busy-flagged).
//  Sits between the CPU decode stage (read addresses) and writeback (write port).
// PARAMETERS
//  N         16  data width in bits (>=1)
//  DEPTH     8   number of entries (>=2, power of two)
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
//  (localparam AW = $clog2(DEPTH): address width)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous reset, active-high
//  wr_en      in   1   write strobe
//  wr_addr    in   AW  write address
//  wr_data    in   N   write data
//  rd_addr_a  in   AW  read port A address
//  rd_data_a  out  N   read port A data, registered
//  rd_addr_b  in   AW  read port B address
//  rd_data_b  out  N   read port B data, registered
//  clr_start  in   1   request sequenced clear of all entries
//  busy       out  1   high while clear sequence runs
// BEHAVIOUR
//  - Reset: all entries, rd_data_a/b = 0, busy = 0, state = IDLE, clear counter = 0. rst wins over
//    every other input, including mid-clear (sequence aborted; array zeroed anyway).
//  - Write: when wr_en=1 and state=IDLE, entry[wr_addr] <= wr_data at clk edge.
//    ZERO_REG=1 and wr_addr=0: write dropped.
//  - Read: 1-cycle latency. rd_data_x at edge k+1 reflects rd_addr_x sampled at edge k.
//  - Bypass: if wr_en=1, IDLE, wr_addr==rd_addr_x (and not zero-reg entry 0), rd_data_x gets
//    wr_data in the same edge (new data, never stale). Both ports bypass independently.
//  - ZERO_REG=1: read of address 0 returns 0 always.
//  - FSM states: IDLE, CLEAR.
//    IDLE --clr_start=1--> CLEAR, busy=1 from next cycle, counter=0.
//    CLEAR: entry[counter] <= 0 each cycle, counter++; at counter==DEPTH-1 the last entry is
//    cleared and FSM -> IDLE, busy=0 next cycle. Clear takes exactly DEPTH cycles.
//    clr_start while CLEAR: ignored (no restart).
//  - During CLEAR: wr_en ignored (write lost; caller must stall on busy); reads still served,
//    returning current array contents (cleared entries read 0). No bypass in CLEAR.
//  - clr_start and wr_en in the same IDLE cycle: write commits this edge, clear starts next; the
//    written value is subsequently cleared.
//  - Counter is AW bits; wrap from DEPTH-1 to 0 coincides with exit to IDLE.
// STRUCTURE
//  - Shared package: state encoding (ST_IDLE, ST_CLEAR), clog2-based AW helper.
//  - One natural sub-module: rf_clear_seq (FSM + counter, outputs busy, clr_we, clr_addr);
//    array, write mux and bypass stay in register_file_n.
// TESTING
//  1 Reset: assert rst 2 cycles with wr_en=1 -> rd_data_a/b=0, busy=0, reads of all addrs =0.
//  2 Write/read: write 0x1234 to addr 3, next cycle rd_addr_a=3 -> rd_data_a=0x1234 one cycle later;
//    write to addr 0 (ZERO_REG=1) value 0xFFFF -> read addr 0 returns 0.
//  3 Bypass: same cycle wr_en=1, wr_addr=5, wr_data=0xBEEF, rd_addr_a=rd_addr_b=5 ->
//    both rd_data=0xBEEF next cycle.
//  4 Clear: fill all 8 entries with 0xAAAA, pulse clr_start -> busy high exactly 8 cycles,
//    all entries read 0 afterward; wr_en=1 during busy has no effect.
//  5 Simultaneous: clr_start + write 0x5555 to addr 2 same cycle -> after clear addr 2 reads 0.
//  6 Reset mid-clear: rst at cycle 3 of CLEAR -> busy=0 next cycle, FSM IDLE, writes accepted.

Source files
------------

// File: rtl/register_file_n_pkg.sv
// Shared definitions for the register file and its clear sequencer:
// sequencer state encoding and the address-width helper.
package register_file_n_pkg;

    // Clear sequencer states: idle (normal read/write) or stepping through entries
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_t;

    // Address width for a given entry count; never narrower than one bit
    function automatic int rf_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : register_file_n_pkg

// File: rtl/register_file_n_clear_seq.sv
// Bulk-clear sequencer: walks a counter over every entry, one per cycle,
// and tells the array which entry to zero. Busy for exactly DEPTH cycles.
module rf_clear_seq
    import register_file_n_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = rf_addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    rf_state_t     state;
    rf_state_t     state_nxt;
    logic [AW-1:0] counter;
    logic [AW-1:0] counter_nxt;

    // State and counter registers; reset aborts any clear in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

    // Next state: start on request from idle, leave after the last entry is cleared
    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        case (state)
            ST_IDLE: begin
                counter_nxt = '0;
                if (clr_start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                counter_nxt = counter + 1'b1;
                if (counter == LAST_ADDR) begin
                    state_nxt   = ST_IDLE;
                    counter_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                counter_nxt = '0;
            end
        endcase
    end

    // Outputs: every CLEAR cycle zeroes the entry the counter points at
    always_comb begin
        busy     = 1'b0;
        clr_we   = 1'b0;
        clr_addr = counter;
        if (state == ST_CLEAR) begin
            busy   = 1'b1;
            clr_we = 1'b1;
        end
    end

endmodule : rf_clear_seq

// File: rtl/register_file_n.sv
// DEPTH x N register file with two registered read ports, one write port,
// write-to-read bypass, optional hardwired-zero entry 0 and a sequenced clear.
module register_file_n
    import register_file_n_pkg::*;
#(
    parameter int N        = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_addr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr_a,
    output logic [N-1:0]  rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [N-1:0]  rd_data_b,
    input  logic          clr_start,
    output logic          busy
);

    logic [N-1:0]  mem [DEPTH];
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_ok;
    logic          bypass_a;
    logic          bypass_b;
    logic          zero_rd_a;
    logic          zero_rd_b;

    rf_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // Write qualification and bypass/zero-entry decode; writes are lost while clearing
    always_comb begin
        wr_ok     = wr_en && !busy && !((ZERO_REG != 0) && (wr_addr == '0));
        bypass_a  = wr_ok && (wr_addr == rd_addr_a);
        bypass_b  = wr_ok && (wr_addr == rd_addr_b);
        zero_rd_a = (ZERO_REG != 0) && (rd_addr_a == '0);
        zero_rd_b = (ZERO_REG != 0) && (rd_addr_b == '0);
    end

    // Array update: reset zeroes everything, clear sequencer has priority over writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered reads with same-edge bypass so a reader never sees stale data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (zero_rd_a) begin
                rd_data_a <= '0;
            end else if (bypass_a) begin
                rd_data_a <= wr_data;
            end else begin
                rd_data_a <= mem[rd_addr_a];
            end
            if (zero_rd_b) begin
                rd_data_b <= '0;
            end else if (bypass_b) begin
                rd_data_b <= wr_data;
            end else begin
                rd_data_b <= mem[rd_addr_b];
            end
        end
    end

endmodule : register_file_n

// File: tb/tb_register_file_n.sv
// Self-checking bench for register_file_n: a behavioural model predicts each
// cycle's read data and busy flag, queued at drive time and compared after the edge.
module tb_register_file_n;

    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_data = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          clr_start = 1'b0;
    logic [N-1:0]  rd_data_a;
    logic [N-1:0]  rd_data_b;
    logic          busy;

    typedef struct {
        string        tag;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         busy;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] model_mem [DEPTH];
    logic         model_busy = 1'b0;
    int           model_cnt = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           busy_cycles;

    register_file_n #(
        .N        (N),
        .DEPTH    (DEPTH),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .clr_start (clr_start),
        .busy      (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                               input logic [N-1:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // Model read of one port as seen at the coming edge (entry 0 hardwired to zero)
    function automatic logic [N-1:0] model_read(input logic [AW-1:0] addr, input logic wr_ok,
                                                input logic [AW-1:0] wa, input logic [N-1:0] wd);
        if (addr == '0) return '0;
        if (wr_ok && (wa == addr)) return wd;
        return model_mem[addr];
    endfunction

    // Drive one cycle, predict its outcome, then compare after the edge
    task automatic applyStimulus(input string tag, input logic r, input logic we,
                                 input logic [AW-1:0] wa, input logic [N-1:0] wd,
                                 input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                                 input logic cs);
        exp_t e;
        logic wr_ok;
        rst       = r;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        clr_start = cs;
        e.tag = tag;
        if (r) begin
            e.a = '0;
            e.b = '0;
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
            model_busy = 1'b0;
            model_cnt  = 0;
        end else begin
            wr_ok = we && !model_busy && (wa != '0);
            e.a = model_read(ra, wr_ok, wa, wd);
            e.b = model_read(rb, wr_ok, wa, wd);
            if (model_busy) begin
                model_mem[model_cnt] = '0;
                if (model_cnt == DEPTH - 1) begin
                    model_busy = 1'b0;
                    model_cnt  = 0;
                end else begin
                    model_cnt++;
                end
            end else begin
                if (wr_ok) model_mem[wa] = wd;
                if (cs) begin
                    model_busy = 1'b1;
                    model_cnt  = 0;
                end
            end
        end
        e.busy = model_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({e.tag, "_a"}, rd_data_a, e.a);
        checkOutput({e.tag, "_b"}, rd_data_b, e.b);
        checkOutput({e.tag, "_busy"}, {{(N-1){1'b0}}, busy}, {{(N-1){1'b0}}, e.busy});
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset held two cycles with a write pending, then every address reads zero
        applyStimulus("rst0", 1'b1, 1'b1, 3'd3, 16'hDEAD, 3'd3, 3'd4, 1'b0);
        applyStimulus("rst1", 1'b1, 1'b1, 3'd4, 16'hBEEF, 3'd4, 3'd3, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("rst_rd", 1'b0, 1'b0, 3'd0, 16'h0, AW'(i), AW'(DEPTH - 1 - i), 1'b0);
        end

        // Plain write then read; entry 0 drops writes
        applyStimulus("wr3", 1'b0, 1'b1, 3'd3, 16'h1234, 3'd1, 3'd2, 1'b0);
        applyStimulus("rd3", 1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 1'b0);
        applyStimulus("wr0", 1'b0, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b0);
        applyStimulus("rd0", 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd3, 1'b0);

        // Bypass on both ports, then on one port only
        applyStimulus("byp5", 1'b0, 1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 1'b0);
        applyStimulus("byp6", 1'b0, 1'b1, 3'd6, 16'hC0DE, 3'd6, 3'd5, 1'b0);
        applyStimulus("byp0", 1'b0, 1'b1, 3'd0, 16'h4321, 3'd0, 3'd6, 1'b0);

        // Fill, then clear with writes attempted while busy
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("fill", 1'b0, 1'b1, AW'(i), 16'hAAAA, AW'(i), AW'((i + 1) % DEPTH), 1'b0);
        end
        busy_cycles = 0;
        applyStimulus("clr_go", 1'b0, 1'b0, 3'd0, 16'h0, 3'd1, 3'd7, 1'b1);
        if (busy) busy_cycles++;
        for (int i = 0; i < 12; i++) begin
            applyStimulus("clr_run", 1'b0, 1'b1, AW'(i % DEPTH), 16'h7777, AW'(i % DEPTH),
                          AW'(DEPTH - 1 - (i % DEPTH)), (i == 2));
            if (busy) busy_cycles++;
        end
        checkOutput("busy_len", N'(busy_cycles), N'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("post_clr", 1'b0, 1'b0, 3'd0, 16'h0, AW'(i), AW'(i), 1'b0);
        end

        // Write and clear request in the same cycle: write lands, then is cleared
        applyStimulus("wr_clr", 1'b0, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("sim_run", 1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd1, 1'b0);
        end
        applyStimulus("sim_rd", 1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd2, 1'b0);

        // Reset in the third clear cycle aborts the sequence; writes resume
        applyStimulus("pre", 1'b0, 1'b1, 3'd4, 16'h9999, 3'd4, 3'd0, 1'b0);
        applyStimulus("mid_go", 1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd4, 1'b1);
        applyStimulus("mid_c1", 1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0);
        applyStimulus("mid_c2", 1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0);
        applyStimulus("mid_rst", 1'b1, 1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 1'b0);
        applyStimulus("mid_wr", 1'b0, 1'b1, 3'd7, 16'h0F0F, 3'd4, 3'd1, 1'b0);
        applyStimulus("mid_rd", 1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd4, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            applyStimulus("rand", 1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                          N'($urandom), AW'($urandom_range(0, DEPTH - 1)),
                          AW'($urandom_range(0, DEPTH - 1)), ($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_file_n
